// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller and MEM/WB pipeline register (optional MEM_TIMEOUT_EN).
// Latency: 1 cycle for non-memory ops; loads >= 2 cycles, 32-bit stores >= 2 cycles, 64-bit stores >= 3 cycles.
// Backpressure: Stall_MEM freezes upstream while a req/ack access is outstanding; dmem_req held until dmem_ack.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemWrite64,
    input  logic [31:0] Adrs_MEM,
    input  logic [31:0] Rt_data_MEM,
    input  logic [63:0] Rt_data64_MEM,
    input  logic [4:0]  RegWr_MEM,
    input  logic [9:0]  WB_control_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        Stall_MEM,
    output logic [31:0] Read_data_WB,
    output logic [31:0] Alu_out_WB,
    output logic [4:0]  RegWr_WB,
    output logic [9:0]  WB_control_WB,
    output logic        Valid_WB,
    output logic        Mem_err
);

    typedef enum logic [2:0] {IDLE, RD, WR, WR_LO, WR_HI} state_t;

    state_t      state;
    logic [31:0] hi_data;
    logic [31:0] lat_adrs;
    logic [4:0]  lat_rd;
    logic [9:0]  lat_wbc;

    logic op;
    logic ack_live;
    logic final_beat;
    logic timeout_hit;
    logic complete;

    assign op         = MemWrite64 | MemWrite | MemRead;
    // An ack only means something while a request is actually on the port.
    assign ack_live   = dmem_ack & dmem_req;
    assign final_beat = (state == RD) | (state == WR) | (state == WR_HI);
    assign complete   = (final_beat & ack_live) | timeout_hit;

    // Stall whenever an access is pending and not retiring this cycle; reset releases it at once.
    assign Stall_MEM  = Rst_n & ((state == IDLE) ? op : ~complete);

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic          in_beat;
    logic [CW-1:0] wait_cnt;

    assign in_beat     = (state != IDLE);
    // Abort on the TIMEOUT_CYCLES-th consecutive cycle of a beat without ack.
    assign timeout_hit = in_beat & ~ack_live & (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Per-beat wait counter: cleared outside beats and at every accepted beat.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wait_cnt <= '0;
        end else if (!in_beat || ack_live) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Mem_err <= 1'b0;
        end else if (timeout_hit) begin
            Mem_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign Mem_err     = 1'b0;
`endif

    // Access FSM with registered memory-port outputs and the MEM/WB register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state         <= IDLE;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            hi_data       <= '0;
            lat_adrs      <= '0;
            lat_rd        <= '0;
            lat_wbc       <= '0;
            Read_data_WB  <= '0;
            Alu_out_WB    <= '0;
            RegWr_WB      <= '0;
            WB_control_WB <= '0;
            Valid_WB      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (op) begin
                        lat_adrs  <= Adrs_MEM;
                        lat_rd    <= RegWr_MEM;
                        lat_wbc   <= WB_control_MEM;
                        dmem_req  <= 1'b1;
                        dmem_addr <= {Adrs_MEM[31:2], 2'b00};
                        Valid_WB  <= 1'b0;
                        if (MemWrite64) begin
                            dmem_we    <= 1'b1;
                            dmem_wdata <= Rt_data64_MEM[31:0];
                            hi_data    <= Rt_data64_MEM[63:32];
                            state      <= WR_LO;
                        end else if (MemWrite) begin
                            dmem_we    <= 1'b1;
                            dmem_wdata <= Rt_data_MEM;
                            state      <= WR;
                        end else begin
                            dmem_we    <= 1'b0;
                            dmem_wdata <= Rt_data_MEM;
                            state      <= RD;
                        end
                    end else begin
                        Read_data_WB  <= '0;
                        Alu_out_WB    <= Adrs_MEM;
                        RegWr_WB      <= RegWr_MEM;
                        WB_control_WB <= WB_control_MEM;
                        Valid_WB      <= 1'b1;
                    end
                end
                default: begin
                    if (timeout_hit) begin
                        dmem_req      <= 1'b0;
                        dmem_we       <= 1'b0;
                        Read_data_WB  <= 32'hDEADBEEF;
                        Alu_out_WB    <= lat_adrs;
                        RegWr_WB      <= lat_rd;
                        WB_control_WB <= lat_wbc;
                        Valid_WB      <= 1'b1;
                        state         <= IDLE;
                    end else if (state == WR_LO && ack_live) begin
                        // Second beat follows with no gap; address wraps naturally at 2^32.
                        dmem_addr  <= dmem_addr + 32'd4;
                        dmem_wdata <= hi_data;
                        Valid_WB   <= 1'b0;
                        state      <= WR_HI;
                    end else if (final_beat && ack_live) begin
                        dmem_req      <= 1'b0;
                        dmem_we       <= 1'b0;
                        Read_data_WB  <= (state == RD) ? dmem_rdata : 32'd0;
                        Alu_out_WB    <= lat_adrs;
                        RegWr_WB      <= lat_rd;
                        WB_control_WB <= lat_wbc;
                        Valid_WB      <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        Valid_WB <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed and random accesses against a beat-level reference model.
// Latency: checks every access cycle by cycle, with memory ack latency chosen per beat.
// Backpressure: inputs are held while the access is in progress, then returned to a non-memory op.
module tb_mem_access_ctrl;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        MemRead, MemWrite, MemWrite64;
    logic [31:0] Adrs_MEM, Rt_data_MEM;
    logic [63:0] Rt_data64_MEM;
    logic [4:0]  RegWr_MEM;
    logic [9:0]  WB_control_MEM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        Stall_MEM;
    logic [31:0] Read_data_WB, Alu_out_WB;
    logic [4:0]  RegWr_WB;
    logic [9:0]  WB_control_WB;
    logic        Valid_WB, Mem_err;

    int   n_pass = 0;
    int   n_total = 0;
    logic mem_err_exp = 1'b0;

    mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemWrite64(MemWrite64),
        .Adrs_MEM(Adrs_MEM), .Rt_data_MEM(Rt_data_MEM), .Rt_data64_MEM(Rt_data64_MEM),
        .RegWr_MEM(RegWr_MEM), .WB_control_MEM(WB_control_MEM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .Stall_MEM(Stall_MEM),
        .Read_data_WB(Read_data_WB), .Alu_out_WB(Alu_out_WB), .RegWr_WB(RegWr_WB),
        .WB_control_WB(WB_control_WB), .Valid_WB(Valid_WB), .Mem_err(Mem_err)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        MemRead        = 1'b0;
        MemWrite       = 1'b0;
        MemWrite64     = 1'b0;
        Adrs_MEM       = $urandom;
        Rt_data_MEM    = $urandom;
        Rt_data64_MEM  = {$urandom, $urandom};
        RegWr_MEM      = 5'($urandom);
        WB_control_MEM = 10'($urandom);
    endtask

    // One instruction through MEM. lat0/lat1 = no-ack cycles before ack on beat 0/1.
    task automatic do_op(input logic rd, input logic wr, input logic w64,
                         input logic [31:0] adrs, input logic [31:0] d32, input logic [63:0] d64,
                         input logic [4:0] rg, input logic [9:0] wbc,
                         input int lat0, input int lat1, input logic [31:0] rdata, input string tag);
        logic        op, isrd;
        int          nb, stalls, exp_stalls;
        logic [31:0] ba[2];
        logic [31:0] bd[2];
        int          lat[2];
        op    = rd | wr | w64;
        isrd  = rd & !wr & !w64;
        nb    = !op ? 0 : (w64 ? 2 : 1);
        ba[0] = {adrs[31:2], 2'b00};
        ba[1] = ba[0] + 32'd4;
        bd[0] = w64 ? d64[31:0] : d32;
        bd[1] = d64[63:32];
        lat[0] = lat0;
        lat[1] = lat1;
        exp_stalls = !op ? 0 : (w64 ? 2 + lat0 + lat1 : 1 + lat0);

        @(negedge Clk);
        MemRead = rd; MemWrite = wr; MemWrite64 = w64;
        Adrs_MEM = adrs; Rt_data_MEM = d32; Rt_data64_MEM = d64;
        RegWr_MEM = rg; WB_control_MEM = wbc;
        dmem_ack   = !op;
        dmem_rdata = $urandom;
        #1 stalls = Stall_MEM ? 1 : 0;

        for (int b = 0; b < nb; b++) begin
            for (int w = 0; w <= lat[b]; w++) begin
                @(negedge Clk);
                check({tag, "/req"},    dmem_req,   1'b1);
                check({tag, "/we"},     dmem_we,    !isrd);
                check({tag, "/addr"},   dmem_addr,  ba[b]);
                check({tag, "/wdata"},  dmem_wdata, bd[b]);
                check({tag, "/bubble"}, Valid_WB,   1'b0);
                dmem_ack   = (w == lat[b]);
                dmem_rdata = (w == lat[b]) ? rdata : $urandom;
                #1 if (Stall_MEM) stalls++;
            end
        end

        @(negedge Clk);
        dmem_ack = 1'b0;
        check({tag, "/stalls"},  stalls,        exp_stalls);
        check({tag, "/req_off"}, dmem_req,      1'b0);
        check({tag, "/valid"},   Valid_WB,      1'b1);
        check({tag, "/rdata"},   Read_data_WB,  isrd ? rdata : 32'd0);
        check({tag, "/alu"},     Alu_out_WB,    adrs);
        check({tag, "/regwr"},   RegWr_WB,      rg);
        check({tag, "/wbc"},     WB_control_WB, wbc);
        check({tag, "/err"},     Mem_err,       mem_err_exp);
        idle_inputs();
    endtask

    initial begin
        Rst_n      = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        idle_inputs();
        repeat (2) @(negedge Clk);
        check("rst/req",   dmem_req,      1'b0);
        check("rst/we",    dmem_we,       1'b0);
        check("rst/addr",  dmem_addr,     32'd0);
        check("rst/wdata", dmem_wdata,    32'd0);
        check("rst/valid", Valid_WB,      1'b0);
        check("rst/rdata", Read_data_WB,  32'd0);
        check("rst/alu",   Alu_out_WB,    32'd0);
        check("rst/regwr", RegWr_WB,      5'd0);
        check("rst/wbc",   WB_control_WB, 10'd0);
        check("rst/err",   Mem_err,       1'b0);
        check("rst/stall", Stall_MEM,     1'b0);
        Rst_n = 1'b1;

        do_op(0, 0, 0, 32'h10, 32'h0, 64'h0, 5'd5, 10'h155, 0, 0, 32'h0, "alu");
        do_op(1, 0, 0, 32'h1003, 32'h0, 64'h0, 5'd7, 10'h2AA, 2, 0, 32'hCAFE0001, "load");
        do_op(0, 0, 1, 32'hFFFFFFFC, 32'h0, 64'h11112222_33334444, 5'd9, 10'h0F0, 0, 0, 32'h0, "st64wrap");
        do_op(1, 1, 0, 32'h20, 32'h55, 64'h0, 5'd3, 10'h00F, 0, 0, 32'h77, "rdwr");
        do_op(1, 1, 1, 32'h42, 32'h99, 64'hAAAA_BBBB_CCCC_DDDD, 5'd1, 10'h3FF, 1, 3, 32'h0, "allset");

        for (int i = 0; i < 40; i++) begin
            do_op(1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, {$urandom, $urandom},
                  5'($urandom), 10'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  $urandom, "rand");
        end

        // Reset in the middle of the low beat of a 64-bit store.
        @(negedge Clk);
        MemWrite64 = 1'b1; Adrs_MEM = 32'h40; Rt_data64_MEM = 64'h1234_5678_9ABC_DEF0;
        dmem_ack = 1'b0;
        @(negedge Clk);
        check("rstmid/req_before", dmem_req, 1'b1);
        #1 Rst_n = 1'b0;
        #1;
        check("rstmid/req",   dmem_req,  1'b0);
        check("rstmid/stall", Stall_MEM, 1'b0);
        idle_inputs();
        @(negedge Clk);
        Rst_n = 1'b1;
        #1;
        check("rstmid/valid_after", Valid_WB,  1'b0);
        check("rstmid/stall_after", Stall_MEM, 1'b0);
        @(negedge Clk);
        check("rstmid/idle_req",   dmem_req, 1'b0);
        check("rstmid/idle_valid", Valid_WB, 1'b1);
        do_op(1, 0, 0, 32'h88, 32'h0, 64'h0, 5'd11, 10'h111, 0, 0, 32'h600D0001, "post_rst");

`ifdef MEM_TIMEOUT_EN
        // Load that is never acked: aborted after 4 wait cycles.
        @(negedge Clk);
        MemRead = 1'b1; Adrs_MEM = 32'h300; RegWr_MEM = 5'd12; WB_control_MEM = 10'h222;
        dmem_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            check("tmo/req", dmem_req, 1'b1);
            #1 check("tmo/stall", Stall_MEM, (k < 3) ? 1'b1 : 1'b0);
        end
        @(negedge Clk);
        mem_err_exp = 1'b1;
        check("tmo/req_off", dmem_req,     1'b0);
        check("tmo/err",     Mem_err,      1'b1);
        check("tmo/rdata",   Read_data_WB, 32'hDEADBEEF);
        check("tmo/valid",   Valid_WB,     1'b1);
        check("tmo/regwr",   RegWr_WB,     5'd12);
        idle_inputs();
        do_op(0, 0, 0, 32'h44, 32'h0, 64'h0, 5'd2, 10'h001, 0, 0, 32'h0, "tmo_sticky");
        do_op(1, 0, 0, 32'h48, 32'h0, 64'h0, 5'd4, 10'h002, 1, 0, 32'h5151, "tmo_after");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
